// File: rtl/copyn_fifo.sv
// copyn_fifo: buffered N-way copy (fork) stage. Tokens enter through a
// DEPTH-entry circular FIFO holding {mask, data}; the head token is offered
// to every output enabled by its mask, either independently (EAGER=1) or in
// lockstep (EAGER=0). All outputs come straight from flops, so out_ready
// has no combinational path to in_ready or out_valid.
module copyn_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NOUT  = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned EAGER = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [NOUT-1:0]              in_mask,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NOUT*WIDTH-1:0]        out_data,
  output logic [NOUT-1:0]              out_valid,
  input  logic [NOUT-1:0]              out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [NOUT-1:0]  mem_mask [DEPTH];

  logic [PW-1:0]          wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [NOUT-1:0]        done, done_n;
  logic [NOUT-1:0]        head_mask, head_mask_n;
  logic [WIDTH-1:0]       head_data, head_data_n;
  logic [CW-1:0]          count_n, remain;
  logic [NOUT-1:0]        xfer;
  logic [NOUT-1:0]        out_valid_n;
  logic [NOUT*WIDTH-1:0]  out_data_n;
  logic                   push, pop, live_n, in_ready_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state: handshakes, pop decision, pointers and the next head view
  always_comb begin
    push        = in_valid && in_ready;
    pop         = 1'b0;
    xfer        = '0;
    done_n      = '0;
    head_mask_n = head_mask;
    head_data_n = head_data;

    if (count != '0) begin
      if (EAGER != 0) begin
        xfer = out_valid & out_ready;
        pop  = (head_mask & ~(done | xfer)) == '0;
      end else begin
        pop  = (head_mask & ~out_ready) == '0;
      end
    end

    if ((EAGER != 0) && !pop) done_n = done | xfer;

    rd_ptr_n = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_n = push ? ptr_inc(wr_ptr) : wr_ptr;
    count_n  = count + CW'(push) - CW'(pop);
    remain   = count - CW'(pop);

    // A token landing in an emptied FIFO becomes head directly from the input
    if (remain == '0) begin
      head_mask_n = push ? in_mask : '0;
      head_data_n = push ? in_data : '0;
    end else if (pop) begin
      head_mask_n = mem_mask[rd_ptr_n];
      head_data_n = mem_data[rd_ptr_n];
    end

    live_n      = count_n != '0;
    out_valid_n = live_n ? (head_mask_n & ~done_n) : '0;
    out_data_n  = live_n ? {NOUT{head_data_n}} : '0;
    in_ready_n  = count_n < CW'(DEPTH);
  end

  // Token storage; contents are only read once written, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_mask[wr_ptr] <= in_mask;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= '0;
      head_mask <= '0;
      head_data <= '0;
      in_ready  <= 1'b0;
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      done      <= done_n;
      head_mask <= head_mask_n;
      head_data <= head_data_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

endmodule
